// File: rtl/arbiter_16.sv
// arbiter_16: 16-requester round-robin arbiter with registered one-hot grant.
// A grant is held until the owner pulses done or drops its request. Every
// release is followed by one IDLE cycle before the next grant is issued.
// Optional feature: define ARB_TIMEOUT_EN to force release after HOLD_MAX
// grant cycles, signalled by a one-cycle tmo pulse.
module arbiter_16 #(
    parameter int HOLD_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        run_q;
    logic [3:0]  ptr;
    logic [3:0]  ptr_nxt;
    logic [15:0] gnt_nxt;
    logic [3:0]  idx_nxt;
    logic        vld_nxt;
    logic        sel_found;
    logic [3:0]  sel_idx;
    logic        owner_rel;
    logic        tmo_nxt;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("arbiter_16: HOLD_MAX must be within 1..255");
    end

`ifdef ARB_TIMEOUT_EN
    // Last count value before the forced release fires; the grant then
    // stays visible for exactly HOLD_MAX cycles.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
`endif

    // Owner gives up the grant by strobing done or by dropping its request.
    assign owner_rel = done | ~req[gnt_idx];

    // Rotating-priority search: first set request at or above ptr, wrapping.
    always_comb begin
        logic [3:0] cand;
        cand      = 4'd0;
        sel_found = 1'b0;
        sel_idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            cand = ptr + 4'(k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_valid;
        tmo_nxt   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            IDLE: begin
                gnt_nxt = 16'd0;
                vld_nxt = 1'b0;
                // run_q holds arbitration off for the first edge after reset
                // release so deassertion behaves as if synchronous.
                if (run_q && sel_found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 16'd1 << sel_idx;
                    idx_nxt   = sel_idx;
                    vld_nxt   = 1'b1;
                    ptr_nxt   = sel_idx + 4'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (owner_rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 16'd0;
                    vld_nxt   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                // A normal release in the same cycle takes precedence, so
                // tmo only fires when the owner is still holding on.
                else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 16'd0;
                    vld_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 16'd0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // Reset-release qualifier: first edge after rst_n rises only arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State, pointer and grant registers; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            gnt       <= 16'd0;
            gnt_idx   <= 4'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= vld_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            tmo      <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            tmo      <= tmo_nxt;
        end
    end
`else
    // Without the timeout feature a grant is held indefinitely.
    assign tmo = 1'b0;

    logic unused_tmo;
    assign unused_tmo = tmo_nxt;
`endif

endmodule

// File: tb/tb_arbiter_16.sv
// tb_arbiter_16: directed, table-driven bench for arbiter_16.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path.
module tb_arbiter_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        tmo;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [15:0] egnt;
        logic [3:0]  eidx;
        logic        evld;
    } vec_t;

    vec_t vecs[$];

    arbiter_16 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [15:0] eg, input logic [3:0] ei,
                           input logic ev, input logic et, input bit ci);
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
        chk({nm, ".tmo"}, 32'(tmo), 32'(et));
        if (ci) chk({nm, ".gnt_idx"}, 32'(gnt_idx), 32'(ei));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_grant(input logic [15:0] r, input logic d, input logic [3:0] i);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.egnt = 16'd1 << i;
        v.eidx = i;
        v.evld = 1'b1;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input logic [15:0] r, input logic d);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.egnt = 16'd0;
        v.eidx = 4'd0;
        v.evld = 1'b0;
        vecs.push_back(v);
    endfunction

    // Grant must always be the one-hot decode of gnt_idx, or zero when idle.
    always @(negedge clk) begin
        logic [15:0] exp_g;
        exp_g = gnt_valid ? (16'd1 << gnt_idx) : 16'd0;
        n_chk++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL onehot: got %0h, expected %0h", gnt, exp_g);
        end
    end

    initial begin
        // Fairness rotation from ptr=1 with owner 0 in place.
        add_grant(16'hFFFF, 1'b0, 4'd0);
        for (int i = 1; i < 16; i++) begin
            add_idle(16'hFFFF, 1'b1);
            add_grant(16'hFFFF, 1'b0, 4'(i));
        end
        add_idle(16'hFFFF, 1'b1);
        add_grant(16'hFFFF, 1'b0, 4'd0);
        // Grant 4, then search from ptr=5 wraps past 15 to index 0.
        add_idle(16'h0010, 1'b1);
        add_grant(16'h0010, 1'b0, 4'd4);
        add_idle(16'h0011, 1'b1);
        add_grant(16'h0011, 1'b0, 4'd0);
        // Owner 3 drops its request; req[7] raised mid-grant waits for IDLE.
        add_idle(16'h0008, 1'b0);
        add_grant(16'h0008, 1'b0, 4'd3);
        add_grant(16'h0088, 1'b0, 4'd3);
        add_idle(16'h0080, 1'b0);
        add_grant(16'h0080, 1'b0, 4'd7);
        // done in IDLE is ignored.
        add_idle(16'h0080, 1'b1);
        add_grant(16'h0080, 1'b1, 4'd7);
        add_idle(16'h0080, 1'b1);
        // No requests: stay idle.
        add_idle(16'h0000, 1'b0);
        add_idle(16'h0000, 1'b0);

        rst_n = 1'b0;
        req   = 16'hFFFF;
        done  = 1'b0;
        step();
        chk_out("rst", 16'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("rst_hold", 16'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        chk_out("rel_e1", 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rel_e2", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].egnt, vecs[i].eidx,
                    vecs[i].evld, 1'b0, vecs[i].evld);
        end

        // Long hold by requester 2, ptr=8 so the search wraps to 2.
        req  = 16'h0004;
        done = 1'b0;
        step();
        chk_out("hold_e0", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            step();
            chk_out($sformatf("hold_e%0d", i), 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
        end
        step();
        chk_out("to_fire", 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("to_regrant", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_out($sformatf("to_hold%0d", i), 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
        end
        done = 1'b1;
        step();
        chk_out("to_vs_done", 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 1; i < 21; i++) begin
            step();
            chk_out($sformatf("hold_e%0d", i), 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
        end
        done = 1'b1;
        step();
        chk_out("hold_rel", 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
        done = 1'b0;
        req  = 16'h0000;
        step();
        chk_out("idle_gap", 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 9.
        req = 16'h0200;
        step();
        chk_out("g9", 16'h0200, 4'd9, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 16'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("arst_hold", 16'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
        step();
        chk_out("arst_e1", 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("arst_e2", 16'h0200, 4'd9, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
